// File: rtl/arm_pkg.sv
// Shared definitions for the arm homing sequencer: register map, control/status bit
// positions, error codes and FSM state types.
package arm_pkg;

    localparam logic [7:0] REG_CTRL   = 8'd0;
    localparam logic [7:0] REG_STATUS = 8'd1;
    localparam logic [7:0] REG_DIV    = 8'd2;
    localparam logic [7:0] REG_STEPS  = 8'd3;

    localparam int unsigned CTRL_GO  = 7;
    localparam int unsigned CTRL_DIS = 6;
    localparam int unsigned CTRL_DIR = 5;
    localparam int unsigned CTRL_POL = 4;

    localparam int unsigned STAT_STEPPING = 0;
    localparam int unsigned STAT_FAULT    = 1;
    localparam int unsigned STAT_LIMIT    = 2;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NO_LIMIT = 2'd1;
    localparam logic [1:0] ERR_FAULT    = 2'd2;
    localparam logic [1:0] ERR_ABORT    = 2'd3;

    typedef enum logic [1:0] {BmIdle, BmSetup, BmSel, BmGap} bm_state_e;

    typedef enum logic [3:0] {
        StIdle, StSeekDiv, StSeekSteps, StSeekCtrl, StSeekWait, StSeekPoll,
        StStop, StBoDiv, StBoSteps, StBoCtrl, StBoWait, StBoPoll,
        StDone, StFailSteps, StFailCtrl
    } seq_state_e;

    // Bit 3 is reserved-zero; the microstep field fills bits [2:0].
    function automatic logic [31:0] ctrl_word(input logic go, input logic dis, input logic dir,
                                              input logic [2:0] microstep);
        logic [31:0] w;
        w           = 32'd0;
        w[2:0]      = microstep;
        w[CTRL_POL] = 1'b1;
        w[CTRL_DIR] = dir;
        w[CTRL_DIS] = dis;
        w[CTRL_GO]  = go;
        return w;
    endfunction

endpackage

// File: rtl/arm_bus_master.sv
// Single-transaction register bus master: one setup cycle, select high 2 (write) or
// 3 (read) cycles, then one idle cycle during which ack pulses.
module arm_bus_master
    import arm_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        rw_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic [7:0]  bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic        bus_rw_o,
    output logic        bus_select_o,
    input  logic [31:0] bus_rdata_i
);

    bm_state_e   st_q, st_d;
    logic        sel_q, sel_d;
    logic        rw_q, rw_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q    <= BmIdle;
            sel_q   <= 1'b0;
            rw_q    <= 1'b1;
            addr_q  <= 8'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= 2'd0;
        end else begin
            st_q    <= st_d;
            sel_q   <= sel_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        sel_d   = sel_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (st_q)
            BmIdle: begin
                if (req_i) begin
                    rw_d    = rw_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    st_d    = BmSetup;
                end
            end
            BmSetup: begin
                sel_d = 1'b1;
                cnt_d = 2'd0;
                st_d  = BmSel;
            end
            BmSel: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == (rw_q ? 2'd2 : 2'd1)) begin
                    sel_d = 1'b0;
                    st_d  = BmGap;
                    if (rw_q) begin
                        rdata_d = bus_rdata_i;
                    end
                end
            end
            BmGap:   st_d = BmIdle;
            default: st_d = BmIdle;
        endcase
    end

    assign ack_o        = (st_q == BmGap);
    assign rdata_o      = rdata_q;
    assign bus_addr_o   = addr_q;
    assign bus_wdata_o  = wdata_q;
    assign bus_rw_o     = rw_q;
    assign bus_select_o = sel_q;

endmodule

// File: rtl/arm_homing_sequencer.sv
// Homes one arm axis: seek toward the limit switch, stop, back off a fixed step count,
// then report done or an error code. Issues one bus transaction per bus state.
module arm_homing_sequencer
    import arm_pkg::*;
#(
    parameter logic [7:0]  AXIS_HADDR    = 8'h00,
    parameter logic        HOME_DIR      = 1'b0,
    parameter logic [2:0]  MICROSTEP     = 3'd0,
    parameter logic [15:0] POLL_INTERVAL = 16'd1200
) (
    input  logic        clk_12MHz,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] seek_div,
    input  logic [31:0] backoff_div,
    input  logic [31:0] max_steps,
    input  logic [31:0] backoff_steps,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        bus_rw,
    output logic        bus_select,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);

    seq_state_e  state_q, state_d, nxt;
    logic        pend_q, pend_d;
    logic        abort_q, abort_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  code_q, code_d, nxt_code;
    logic        error_q, error_d;
    logic [1:0]  error_code_q, error_code_d;

    logic        bm_req, bm_rw, bm_ack, is_bus, is_fail, abort_now;
    logic [7:0]  bm_off;
    logic [31:0] bm_wdata, bm_rdata;
    logic [2:0]  status;
    logic        unused_rdata;

    assign status       = bm_rdata[2:0];
    assign unused_rdata = ^bm_rdata[31:3];
    assign abort_now    = abort_q | abort;
    assign is_fail      = (state_q == StFailSteps) || (state_q == StFailCtrl);

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q      <= StIdle;
            pend_q       <= 1'b0;
            abort_q      <= 1'b0;
            cnt_q        <= 16'd0;
            code_q       <= ERR_NONE;
            error_q      <= 1'b0;
            error_code_q <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            error_q      <= error_d;
            error_code_q <= error_code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        abort_d      = abort_q;
        cnt_d        = cnt_q;
        code_d       = code_q;
        error_d      = error_q;
        error_code_d = error_code_q;
        nxt          = state_q;
        nxt_code     = code_q;
        is_bus       = 1'b0;
        bm_req       = 1'b0;
        bm_rw        = 1'b0;
        bm_off       = REG_CTRL;
        bm_wdata     = 32'd0;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d      = StSeekDiv;
                    error_d      = 1'b0;
                    error_code_d = ERR_NONE;
                    abort_d      = 1'b0;
                end
            end
            StSeekDiv:   begin is_bus = 1'b1; bm_off = REG_DIV;   bm_wdata = seek_div;  nxt = StSeekSteps; end
            StSeekSteps: begin is_bus = 1'b1; bm_off = REG_STEPS; bm_wdata = max_steps; nxt = StSeekCtrl; end
            StSeekCtrl: begin
                is_bus   = 1'b1;
                bm_wdata = ctrl_word(1'b1, 1'b0, HOME_DIR, MICROSTEP);
                nxt      = StSeekWait;
            end
            StSeekWait, StBoWait: begin
                if (abort_now) begin
                    state_d = StFailSteps;
                    code_d  = ERR_ABORT;
                end else if (cnt_q <= 16'd1) begin
                    state_d = (state_q == StSeekWait) ? StSeekPoll : StBoPoll;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StSeekPoll: begin
                is_bus = 1'b1;
                bm_rw  = 1'b1;
                bm_off = REG_STATUS;
                if (status[STAT_FAULT]) begin
                    nxt = StFailSteps; nxt_code = ERR_FAULT;
                end else if (status[STAT_LIMIT]) begin
                    nxt = StStop;
                end else if (!status[STAT_STEPPING]) begin
                    nxt = StFailSteps; nxt_code = ERR_NO_LIMIT;
                end else begin
                    nxt = StSeekWait;
                end
            end
            StStop: begin
                is_bus = 1'b1;
                bm_off = REG_STEPS;
                nxt    = (backoff_steps == 32'd0) ? StDone : StBoDiv;
            end
            StBoDiv:   begin is_bus = 1'b1; bm_off = REG_DIV;   bm_wdata = backoff_div;   nxt = StBoSteps; end
            StBoSteps: begin is_bus = 1'b1; bm_off = REG_STEPS; bm_wdata = backoff_steps; nxt = StBoCtrl; end
            StBoCtrl: begin
                is_bus   = 1'b1;
                bm_wdata = ctrl_word(1'b1, 1'b0, ~HOME_DIR, MICROSTEP);
                nxt      = StBoWait;
            end
            StBoPoll: begin
                is_bus = 1'b1;
                bm_rw  = 1'b1;
                bm_off = REG_STATUS;
                if (status[STAT_FAULT]) begin
                    nxt = StFailSteps; nxt_code = ERR_FAULT;
                end else if (!status[STAT_STEPPING]) begin
                    nxt = StDone;
                end else begin
                    nxt = StBoWait;
                end
            end
            StDone:      state_d = StIdle;
            StFailSteps: begin is_bus = 1'b1; bm_off = REG_STEPS; nxt = StFailCtrl; end
            StFailCtrl: begin
                is_bus   = 1'b1;
                bm_wdata = ctrl_word(1'b0, 1'b1, HOME_DIR, MICROSTEP);
                nxt      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort never cuts a transaction short; it is honoured between transactions.
        if (is_bus) begin
            if (!pend_q) begin
                if (abort_now && !is_fail) begin
                    state_d = StFailSteps;
                    code_d  = ERR_ABORT;
                end else begin
                    bm_req = 1'b1;
                    pend_d = 1'b1;
                end
            end else if (bm_ack) begin
                pend_d = 1'b0;
                if (abort_now && !is_fail) begin
                    state_d = StFailSteps;
                    code_d  = ERR_ABORT;
                end else begin
                    state_d = nxt;
                    code_d  = nxt_code;
                    if (state_q == StFailCtrl) begin
                        error_d      = 1'b1;
                        error_code_d = code_q;
                    end
                end
            end
        end

        if (abort && state_q != StIdle) begin
            abort_d = 1'b1;
        end
        if ((state_d == StSeekWait || state_d == StBoWait) && state_d != state_q) begin
            cnt_d = POLL_INTERVAL;
        end
    end

    arm_bus_master u_bus_master (
        .clk_i        (clk_12MHz),
        .rst_i        (reset),
        .req_i        (bm_req),
        .rw_i         (bm_rw),
        .addr_i       (AXIS_HADDR + bm_off),
        .wdata_i      (bm_wdata),
        .ack_o        (bm_ack),
        .rdata_o      (bm_rdata),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_rw_o     (bus_rw),
        .bus_select_o (bus_select),
        .bus_rdata_i  (bus_rdata)
    );

    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);
    assign error      = error_q;
    assign error_code = error_code_q;

endmodule
